// File: rtl/ten_g_pkt_gen_pkg.sv
// Shared types and default parameters for the 10G AXI-Stream frame generator.
package ten_g_pkt_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_IFG  = 2'd2
    } state_e;

    localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;
    localparam int unsigned DEF_MIN_LEN   = 60;
    localparam int unsigned DEF_MAX_LEN   = 1514;

    // Clamp a requested frame length into [lo, hi].
    function automatic logic [15:0] clamp_len(input logic [15:0] req,
                                              input logic [15:0] lo,
                                              input logic [15:0] hi);
        logic [15:0] res;
        res = req;
        if (req < lo) res = lo;
        if (req > hi) res = hi;
        return res;
    endfunction

endpackage

// File: rtl/ten_g_pkt_gen_beat.sv
// Combinational beat former: builds one 64-bit beat of the generated frame
// (header fields, sequence number, incrementing payload) from the beat index.
module ten_g_pkt_gen_beat
    import ten_g_pkt_gen_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE = DEF_ETHERTYPE
) (
    input  logic [12:0] beat_idx,
    input  logic [15:0] frame_len,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [31:0] seq_num,
    output logic [63:0] beat_data,
    output logic [7:0]  beat_keep,
    output logic        beat_last
);

    // Header byte for frame offsets 0..17, all fields MSB first.
    function automatic logic [7:0] hdr_byte(input logic [4:0]  idx,
                                            input logic [47:0] dst,
                                            input logic [47:0] src,
                                            input logic [31:0] seq);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            5'd0:  b = dst[47:40];
            5'd1:  b = dst[39:32];
            5'd2:  b = dst[31:24];
            5'd3:  b = dst[23:16];
            5'd4:  b = dst[15:8];
            5'd5:  b = dst[7:0];
            5'd6:  b = src[47:40];
            5'd7:  b = src[39:32];
            5'd8:  b = src[31:24];
            5'd9:  b = src[23:16];
            5'd10: b = src[15:8];
            5'd11: b = src[7:0];
            5'd12: b = ETHERTYPE[15:8];
            5'd13: b = ETHERTYPE[7:0];
            5'd14: b = seq[31:24];
            5'd15: b = seq[23:16];
            5'd16: b = seq[15:8];
            5'd17: b = seq[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic [15:0] byte_n;
    logic [7:0]  byte_v;

    // Per-lane byte selection; lanes past the frame end are masked and zeroed.
    always_comb begin
        beat_data = '0;
        beat_keep = '0;
        byte_n    = '0;
        byte_v    = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            byte_n = {beat_idx, i[2:0]};
            if (byte_n < 16'd18) begin
                byte_v = hdr_byte(byte_n[4:0], dst_mac, src_mac, seq_num);
            end else begin
                byte_v = byte_n[7:0];
            end
            if (byte_n < frame_len) begin
                beat_data[8*i +: 8] = byte_v;
                beat_keep[i]        = 1'b1;
            end
        end
    end

    // Last beat once this beat reaches or passes the frame length.
    always_comb begin
        beat_last = (({beat_idx, 3'b000} + 16'd8) >= frame_len);
    end

endmodule

// File: rtl/ten_g_axis_pkt_gen.sv
// 10G AXI-Stream test frame generator: FSM, counters and registered AXIS
// outputs. A mid-frame reset abandons the frame; the downstream MAC must be
// reset alongside (tx_axis_aresetn) so it discards the partial frame.
module ten_g_axis_pkt_gen
    import ten_g_pkt_gen_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE = DEF_ETHERTYPE,
    parameter int unsigned MIN_LEN   = DEF_MIN_LEN,
    parameter int unsigned MAX_LEN   = DEF_MAX_LEN
) (
    input  logic        tx_axis_fifo_aclk,
    input  logic        reset,
    input  logic        Enable,
    input  logic [15:0] FrameLen,
    input  logic [7:0]  IfgCycles,
    input  logic [47:0] DstMac,
    input  logic [47:0] SrcMac,
    input  logic        CntClr,
    output logic [63:0] tx_axis_fifo_tdata,
    output logic [7:0]  tx_axis_fifo_tkeep,
    output logic        tx_axis_fifo_tvalid,
    output logic        tx_axis_fifo_tlast,
    input  logic        tx_axis_fifo_tready,
    output logic [31:0] TxPkg_Cnt,
    output logic        Busy
);

    state_e      state_q,   state_d;
    logic [12:0] beat_q,    beat_d;
    logic [15:0] len_q,     len_d;
    logic [47:0] dst_q,     dst_d;
    logic [47:0] src_q,     src_d;
    logic [7:0]  ifg_len_q, ifg_len_d;
    logic [7:0]  ifg_cnt_q, ifg_cnt_d;
    logic [31:0] seq_q,     seq_d;
    logic [31:0] cnt_q,     cnt_d;
    logic [63:0] tdata_q,   tdata_d;
    logic [7:0]  tkeep_q,   tkeep_d;
    logic        tlast_q,   tlast_d;
    logic        tvalid_q,  tvalid_d;
    logic        cnt_inc;

    logic [15:0] req_len;
    logic [12:0] sel_idx;
    logic [15:0] sel_len;
    logic [47:0] sel_dst;
    logic [47:0] sel_src;
    logic [63:0] nxt_data;
    logic [7:0]  nxt_keep;
    logic        nxt_last;

    // Beat former sees live inputs in IDLE (to preload beat 0 while latching)
    // and the latched frame parameters with the following beat index otherwise.
    always_comb begin
        req_len = clamp_len(FrameLen, 16'(MIN_LEN), 16'(MAX_LEN));
        if (state_q == ST_IDLE) begin
            sel_idx = '0;
            sel_len = req_len;
            sel_dst = DstMac;
            sel_src = SrcMac;
        end else begin
            sel_idx = beat_q + 13'd1;
            sel_len = len_q;
            sel_dst = dst_q;
            sel_src = src_q;
        end
    end

    ten_g_pkt_gen_beat #(
        .ETHERTYPE (ETHERTYPE)
    ) u_beat (
        .beat_idx  (sel_idx),
        .frame_len (sel_len),
        .dst_mac   (sel_dst),
        .src_mac   (sel_src),
        .seq_num   (seq_q),
        .beat_data (nxt_data),
        .beat_keep (nxt_keep),
        .beat_last (nxt_last)
    );

    // Next-state, frame latching and output register loading.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        len_d     = len_q;
        dst_d     = dst_q;
        src_d     = src_q;
        ifg_len_d = ifg_len_q;
        ifg_cnt_d = ifg_cnt_q;
        seq_d     = seq_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tlast_d   = tlast_q;
        tvalid_d  = tvalid_q;
        cnt_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    state_d   = ST_DATA;
                    len_d     = req_len;
                    dst_d     = DstMac;
                    src_d     = SrcMac;
                    ifg_len_d = IfgCycles;
                    beat_d    = '0;
                    tvalid_d  = 1'b1;
                    tdata_d   = nxt_data;
                    tkeep_d   = nxt_keep;
                    tlast_d   = nxt_last;
                end
            end
            ST_DATA: begin
                if (tvalid_q && tx_axis_fifo_tready) begin
                    if (tlast_q) begin
                        cnt_inc  = 1'b1;
                        seq_d    = seq_q + 32'd1;
                        tvalid_d = 1'b0;
                        tdata_d  = '0;
                        tkeep_d  = '0;
                        tlast_d  = 1'b0;
                        if (ifg_len_q != 8'd0) begin
                            state_d   = ST_IFG;
                            ifg_cnt_d = ifg_len_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        beat_d  = beat_q + 13'd1;
                        tdata_d = nxt_data;
                        tkeep_d = nxt_keep;
                        tlast_d = nxt_last;
                    end
                end
            end
            ST_IFG: begin
                ifg_cnt_d = ifg_cnt_q - 8'd1;
                if (ifg_cnt_q <= 8'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame counter: clear takes priority over a same-cycle increment.
    always_comb begin
        if (CntClr) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {31'd0, cnt_inc};
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge tx_axis_fifo_aclk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            len_q     <= '0;
            dst_q     <= '0;
            src_q     <= '0;
            ifg_len_q <= '0;
            ifg_cnt_q <= '0;
            seq_q     <= '0;
            cnt_q     <= '0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            len_q     <= len_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            ifg_len_q <= ifg_len_d;
            ifg_cnt_q <= ifg_cnt_d;
            seq_q     <= seq_d;
            cnt_q     <= cnt_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tlast_q   <= tlast_d;
            tvalid_q  <= tvalid_d;
        end
    end

    assign tx_axis_fifo_tdata  = tdata_q;
    assign tx_axis_fifo_tkeep  = tkeep_q;
    assign tx_axis_fifo_tlast  = tlast_q;
    assign tx_axis_fifo_tvalid = tvalid_q;
    assign TxPkg_Cnt           = cnt_q;
    assign Busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ten_g_axis_pkt_gen.sv
// Directed bench for ten_g_axis_pkt_gen: frame content, lengths, stalls,
// inter-frame gap, counter clear and asynchronous reset.
module tb_ten_g_axis_pkt_gen;

    localparam logic [47:0] DST = 48'h0102_0304_0506;
    localparam logic [47:0] SRC = 48'hA1B2_C3D4_E5F6;
    localparam logic [15:0] ETH = 16'h88B5;

    logic        clk = 1'b0;
    logic        reset;
    logic        Enable;
    logic [15:0] FrameLen;
    logic [7:0]  IfgCycles;
    logic [47:0] DstMac;
    logic [47:0] SrcMac;
    logic        CntClr;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic [31:0] TxPkg_Cnt;
    logic        Busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0]  frame_exp [0:2047];
    int          beats_got;
    logic [63:0] first_data;
    logic [63:0] last_data;
    logic [7:0]  last_keep;

    ten_g_axis_pkt_gen #(
        .ETHERTYPE (16'h88B5),
        .MIN_LEN   (60),
        .MAX_LEN   (1514)
    ) dut (
        .tx_axis_fifo_aclk   (clk),
        .reset               (reset),
        .Enable              (Enable),
        .FrameLen            (FrameLen),
        .IfgCycles           (IfgCycles),
        .DstMac              (DstMac),
        .SrcMac              (SrcMac),
        .CntClr              (CntClr),
        .tx_axis_fifo_tdata  (tdata),
        .tx_axis_fifo_tkeep  (tkeep),
        .tx_axis_fifo_tvalid (tvalid),
        .tx_axis_fifo_tlast  (tlast),
        .tx_axis_fifo_tready (tready),
        .TxPkg_Cnt           (TxPkg_Cnt),
        .Busy                (Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_frame(input int len, input logic [47:0] dst,
                               input logic [47:0] src, input logic [31:0] seq);
        for (int k = 0; k < len; k++) begin
            if (k < 6)       frame_exp[k] = 8'(dst >> (8 * (5 - k)));
            else if (k < 12) frame_exp[k] = 8'(src >> (8 * (11 - k)));
            else if (k < 14) frame_exp[k] = 8'(ETH >> (8 * (13 - k)));
            else if (k < 18) frame_exp[k] = 8'(seq >> (8 * (17 - k)));
            else             frame_exp[k] = 8'(k);
        end
    endtask

    // Collect one frame, checking every accepted beat and stall stability.
    task automatic get_frame(input int len, input logic [47:0] dst, input logic [47:0] src,
                             input logic [31:0] seq, input bit rnd, input int drop_at,
                             input bit scramble, input bit clr_last);
        int          budget;
        bit          done;
        bit          was_v;
        logic [63:0] ed, hd;
        logic [7:0]  ek, hk;
        logic        el, hl;
        int          n;
        build_frame(len, dst, src, seq);
        beats_got = 0;
        done      = 1'b0;
        budget    = 0;
        while (!tvalid && budget < 50) begin
            tick();
            budget++;
        end
        check("frame_start", {63'd0, tvalid}, 64'd1);
        if (!tvalid) return;
        budget = 0;
        while (!done && budget < 4000) begin
            budget++;
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tvalid && tready) begin
                ed = '0;
                ek = '0;
                for (int i = 0; i < 8; i++) begin
                    n = beats_got * 8 + i;
                    if (n < len) begin
                        ed[8*i +: 8] = frame_exp[n];
                        ek[i]        = 1'b1;
                    end
                end
                el = ((beats_got + 1) * 8 >= len);
                check("tdata", tdata, ed);
                check("tkeep", {56'd0, tkeep}, {56'd0, ek});
                check("tlast", {63'd0, tlast}, {63'd0, el});
                if (beats_got == 0) first_data = tdata;
                if (tlast) begin
                    done      = 1'b1;
                    last_data = tdata;
                    last_keep = tkeep;
                    if (clr_last) CntClr = 1'b1;
                end
                if (beats_got == drop_at) Enable = 1'b0;
                if (scramble && beats_got == 1) begin
                    FrameLen = 16'd100;
                    SrcMac   = '0;
                    DstMac   = '0;
                end
                beats_got++;
                tick();
                CntClr = 1'b0;
            end else begin
                hd    = tdata;
                hk    = tkeep;
                hl    = tlast;
                was_v = tvalid;
                tick();
                if (was_v) begin
                    check("stall_valid", {63'd0, tvalid}, 64'd1);
                    check("stall_data", tdata, hd);
                    check("stall_keep", {56'd0, tkeep}, {56'd0, hk});
                    check("stall_last", {63'd0, tlast}, {63'd0, hl});
                end
            end
        end
        tready = 1'b1;
        check("frame_done", {63'd0, done}, 64'd1);
    endtask

    // Count low-tvalid samples before the next frame starts.
    task automatic gap_check(input int exp_gap);
        int g;
        g = 0;
        while (!tvalid && g < 20) begin
            g++;
            tick();
        end
        check("ifg_gap", 64'(g), 64'(exp_gap));
    endtask

    initial begin
        int busy_n;
        int valid_n;
        int budget;

        reset     = 1'b1;
        Enable    = 1'b0;
        FrameLen  = 16'd64;
        IfgCycles = 8'd0;
        DstMac    = DST;
        SrcMac    = SRC;
        CntClr    = 1'b0;
        tready    = 1'b1;
        tick();
        tick();
        check("rst_tvalid", {63'd0, tvalid}, 64'd0);
        check("rst_tlast", {63'd0, tlast}, 64'd0);
        check("rst_tdata", tdata, 64'd0);
        check("rst_tkeep", {56'd0, tkeep}, 64'd0);
        check("rst_cnt", {32'd0, TxPkg_Cnt}, 64'd0);
        check("rst_busy", {63'd0, Busy}, 64'd0);
        reset = 1'b0;
        tick();

        // Back-to-back frames: 64 bytes, then 10 (clamped to 60), then 61.
        Enable = 1'b1;
        get_frame(64, DST, SRC, 32'd0, 1'b0, -1, 1'b0, 1'b0);
        check("a_beats", 64'(beats_got), 64'd8);
        check("a_beat0", {16'd0, first_data[47:0]}, 64'h0000_0605_0403_0201);
        check("a_keep", {56'd0, last_keep}, 64'hFF);
        check("a_cnt", {32'd0, TxPkg_Cnt}, 64'd1);
        FrameLen = 16'd10;
        gap_check(1);
        get_frame(60, DST, SRC, 32'd1, 1'b0, -1, 1'b0, 1'b0);
        check("b_beats", 64'(beats_got), 64'd8);
        check("b_keep", {56'd0, last_keep}, 64'h0F);
        FrameLen = 16'd61;
        gap_check(1);
        get_frame(61, DST, SRC, 32'd2, 1'b0, -1, 1'b0, 1'b0);
        Enable = 1'b0;
        check("c_beats", 64'(beats_got), 64'd8);
        check("c_keep", {56'd0, last_keep}, 64'h1F);
        check("c_cnt", {32'd0, TxPkg_Cnt}, 64'd3);
        tick();
        tick();
        check("idle_no_frame", {63'd0, tvalid}, 64'd0);

        // Max length with random backpressure; inputs scrambled mid-frame.
        FrameLen = 16'd1514;
        Enable   = 1'b1;
        get_frame(1514, DST, SRC, 32'd3, 1'b1, -1, 1'b1, 1'b0);
        Enable = 1'b0;
        check("max_beats", 64'(beats_got), 64'd190);
        check("max_keep", {56'd0, last_keep}, 64'h03);
        check("max_byte1513", {56'd0, last_data[15:8]}, 64'hE9);
        check("max_cnt", {32'd0, TxPkg_Cnt}, 64'd4);

        // Enable dropped mid-frame with a 5-cycle gap.
        FrameLen  = 16'd64;
        DstMac    = DST;
        SrcMac    = SRC;
        IfgCycles = 8'd5;
        Enable    = 1'b1;
        get_frame(64, DST, SRC, 32'd4, 1'b0, 3, 1'b0, 1'b0);
        check("drop_beats", 64'(beats_got), 64'd8);
        busy_n  = 0;
        valid_n = 0;
        for (int c = 0; c < 40; c++) begin
            if (Busy) busy_n++;
            if (tvalid) valid_n++;
            tick();
        end
        check("drop_ifg_len", 64'(busy_n), 64'd5);
        check("drop_no_more", 64'(valid_n), 64'd0);
        check("drop_cnt", {32'd0, TxPkg_Cnt}, 64'd5);

        // Counter clear coincident with the final handshake.
        IfgCycles = 8'd0;
        Enable    = 1'b1;
        get_frame(64, DST, SRC, 32'd5, 1'b0, -1, 1'b0, 1'b1);
        check("clr_cnt", {32'd0, TxPkg_Cnt}, 64'd0);
        get_frame(64, DST, SRC, 32'd6, 1'b0, -1, 1'b0, 1'b0);
        Enable = 1'b0;
        check("clr_cnt_after", {32'd0, TxPkg_Cnt}, 64'd1);
        tick();

        // Asynchronous reset while beat 4 is presented.
        Enable = 1'b1;
        budget = 0;
        while (!tvalid && budget < 50) begin
            tick();
            budget++;
        end
        for (int b = 0; b < 4; b++) tick();
        check("pre_rst_valid", {63'd0, tvalid}, 64'd1);
        reset = 1'b1;
        #1;
        check("arst_tvalid", {63'd0, tvalid}, 64'd0);
        check("arst_tdata", tdata, 64'd0);
        check("arst_busy", {63'd0, Busy}, 64'd0);
        check("arst_cnt", {32'd0, TxPkg_Cnt}, 64'd0);
        tick();
        reset = 1'b0;
        get_frame(64, DST, SRC, 32'd0, 1'b0, -1, 1'b0, 1'b0);
        Enable = 1'b0;
        check("post_rst_cnt", {32'd0, TxPkg_Cnt}, 64'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
